// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - op codes, flag indices and helpers shared by the alu_pipe slice
package alu_pipe_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_NOTA  = 3'b010;
    localparam logic [2:0] OP_NOTB  = 3'b011;
    localparam logic [2:0] OP_OR    = 3'b100;
    localparam logic [2:0] OP_ORNB  = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_ANDNB = 3'b111;

    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    // Only the two adder ops produce carry/overflow and update the stored carry.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: b-invert mux, adder, result select
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] f,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             add_c;
    logic             add_v;

    // op[0] selects ~b for every op that names it, and for subtraction.
    assign bx  = op[0] ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};

    assign add_c = sum[WIDTH];
    // Signed overflow: like-signed addends giving a result of the other sign.
    assign add_v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        f = sum[WIDTH-1:0];
        c = 1'b0;
        v = 1'b0;
        unique case (op[2:1])
            2'b00: begin
                f = sum[WIDTH-1:0];
                c = add_c;
                v = add_v;
            end
            2'b01:   f = op[0] ? bx : ~a;
            2'b10:   f = a | bx;
            default: f = a & bx;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with stored carry flag
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_cf,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [3:0]       flags,
    output logic             cf
);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic             s1_use_cf;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s1_load;
    logic             s2_load;
    logic             xfer;

    logic             core_ci;
    logic [WIDTH-1:0] core_f;
    logic             core_c;
    logic             core_v;
    logic [3:0]       core_flags;

    // S2 can take a new value whenever its current one is gone or leaving.
    assign s2_load  = !out_valid || out_ready;
    assign xfer     = s1_valid && s2_load;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // cf is read live, so an op following a carry-producing op sees the new
    // carry as soon as that op has moved into S2.
    assign core_ci = s1_use_cf ? cf : s1_op[0];

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op (s1_op),
        .a  (s1_a),
        .b  (s1_b),
        .ci (core_ci),
        .f  (core_f),
        .c  (core_c),
        .v  (core_v)
    );

    always_comb begin
        core_flags     = 4'b0000;
        core_flags[FZ] = (core_f == '0);
        core_flags[FN] = core_f[WIDTH-1];
        core_flags[FC] = core_c;
        core_flags[FV] = core_v;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
        end
    end

    // Operand registers need no reset; s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (s1_load && in_valid) begin
            s1_op     <= op;
            s1_use_cf <= use_cf;
            s1_a      <= a;
            s1_b      <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            f         <= '0;
            flags     <= 4'b0000;
            cf        <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
            end
            if (xfer) begin
                f     <= core_f;
                flags <= core_flags;
                if (is_arith(s1_op)) begin
                    cf <= core_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic             use_cf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic [3:0]       flags;
    logic             cf;

    int tests;
    int fails;

    alu_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_cf    (use_cf),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .flags     (flags),
        .cf        (cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic u,
                         input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb);
        in_valid = v;
        op       = o;
        use_cf   = u;
        a        = aa;
        b        = bb;
    endtask

    logic [WIDTH-1:0] bp_a   [4];
    logic [WIDTH-1:0] bp_b   [4];
    logic [WIDTH-1:0] bp_exp [4];
    int ip;
    int oi;
    logic hs_in;
    logic hs_out;
    logic any_out;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_f", 64'(f), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_cf", 64'(cf), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Plain add with carry-out wrapping to zero.
        drive(1'b1, OP_ADD, 1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        chk("add_lat1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_f", 64'(f), 64'h0000);
        chk("add_flags", 64'(flags), 64'b1010);
        chk("add_cf", 64'(cf), 64'd1);
        @(negedge clk);
        chk("add_drained", 64'(out_valid), 64'd0);

        // Subtract with signed overflow.
        drive(1'b1, OP_SUB, 1'b0, 16'h8000, 16'h0001);
        @(negedge clk);
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        @(negedge clk);
        chk("sub_out_valid", 64'(out_valid), 64'd1);
        chk("sub_f", 64'(f), 64'h7FFF);
        chk("sub_flags", 64'(flags), 64'b0011);
        chk("sub_cf", 64'(cf), 64'd1);

        // Logic op must leave cf (currently 1) alone.
        drive(1'b1, OP_NOTA, 1'b0, 16'h00FF, 16'h1234);
        @(negedge clk);
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        @(negedge clk);
        chk("nota_f", 64'(f), 64'hFF00);
        chk("nota_flags", 64'(flags), 64'b0100);
        chk("nota_cf", 64'(cf), 64'd1);
        @(negedge clk);

        // Dependent carry chain, back to back.
        drive(1'b1, OP_ADD, 1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        drive(1'b1, OP_ADD, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        chk("chain1_out_valid", 64'(out_valid), 64'd1);
        chk("chain1_f", 64'(f), 64'h0000);
        chk("chain1_cf", 64'(cf), 64'd1);
        @(negedge clk);
        chk("chain2_out_valid", 64'(out_valid), 64'd1);
        chk("chain2_f", 64'(f), 64'h0001);
        chk("chain2_flags", 64'(flags), 64'b0000);
        chk("chain2_cf", 64'(cf), 64'd0);
        @(negedge clk);
        chk("chain_drained", 64'(out_valid), 64'd0);

        // Backpressure: 4 ANDs, out_ready low for the first 5 cycles.
        bp_a[0] = 16'hF0F0; bp_b[0] = 16'h0FF0; bp_exp[0] = 16'h00F0;
        bp_a[1] = 16'h1234; bp_b[1] = 16'h00FF; bp_exp[1] = 16'h0034;
        bp_a[2] = 16'hFFFF; bp_b[2] = 16'h8001; bp_exp[2] = 16'h8001;
        bp_a[3] = 16'hAAAA; bp_b[3] = 16'h5555; bp_exp[3] = 16'h0000;
        ip = 0;
        oi = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            if (ip < 4) drive(1'b1, OP_AND, 1'b0, bp_a[ip], bp_b[ip]);
            else        drive(1'b0, OP_AND, 1'b0, '0, '0);
            #1;
            if (cyc == 2) begin
                chk("bp_in_ready_low", 64'(in_ready), 64'd0);
                chk("bp_accepted", 64'(ip), 64'd2);
            end
            if (cyc >= 2 && cyc < 5) chk("bp_f_hold", 64'(f), 64'(bp_exp[0]));
            hs_in  = in_valid & in_ready;
            hs_out = out_valid & out_ready;
            if (hs_out) begin
                if (oi < 4) chk("bp_order", 64'(f), 64'(bp_exp[oi]));
                else        chk("bp_extra_beat", 64'(oi), 64'd3);
                oi++;
            end
            if (hs_in) ip++;
            @(negedge clk);
        end
        chk("bp_count", 64'(oi), 64'd4);
        chk("bp_cf_unchanged", 64'(cf), 64'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 1'b0, 16'hFFFF, 16'h0001);
        @(negedge clk);
        drive(1'b1, OP_ADD, 1'b0, 16'h0001, 16'h0001);
        @(negedge clk);
        drive(1'b0, OP_ADD, 1'b0, '0, '0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_cf", 64'(cf), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_cf", 64'(cf), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        any_out = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            any_out = any_out | out_valid;
        end
        chk("mid_rst_no_stale", 64'(any_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
